// File: rtl/multicycle_ctrl.sv
// Multi-cycle control FSM for the RV32I core: fetch, decode, execute, memory, writeback.
// Drives datapath enables and the instruction/data memory request-ack handshakes.
module multicycle_ctrl #(
    parameter int unsigned MEM_TIMEOUT  = 16,
    parameter bit          ILLEGAL_HALT = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    input  logic        imem_ack,
    input  logic [31:0] instr,
    output logic        ir_we,
    output logic        dmem_req,
    output logic        dmem_we,
    input  logic        dmem_ack,
    input  logic        br_taken,
    output logic        alu_src_imm,
    output logic        rf_we,
    output logic        wb_sel_mem,
    output logic        pc_we,
    output logic        pc_sel_branch,
    output logic        retired,
    output logic        illegal,
    output logic        bus_err,
    output logic [2:0]  state
);

    localparam int unsigned CNT_W = $clog2(MEM_TIMEOUT);

    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_HALT   = 3'd5
    } state_t;

    state_t             r_state;
    logic [6:0]         r_opcode;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_imem_req;
    logic               r_illegal;
    logic               r_bus_err;

    logic w_is_opimm, w_is_load, w_is_store, w_is_branch, w_is_op, w_legal;
    logic w_timeout;
    logic w_unused_instr;

    assign w_is_opimm  = (r_opcode == OPC_OPIMM);
    assign w_is_load   = (r_opcode == OPC_LOAD);
    assign w_is_store  = (r_opcode == OPC_STORE);
    assign w_is_branch = (r_opcode == OPC_BRANCH);
    assign w_is_op     = (r_opcode == OPC_OP);
    assign w_legal     = w_is_opimm | w_is_load | w_is_store | w_is_branch | w_is_op;
    assign w_timeout   = (r_cnt == CNT_W'(MEM_TIMEOUT - 1));
    assign w_unused_instr = ^instr[31:7];

    assign imem_req = r_imem_req;
    assign illegal  = r_illegal;
    assign bus_err  = r_bus_err;
    assign state    = 3'(r_state);

    // State sequencing, handshake timeout and sticky error flags
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_FETCH;
            r_opcode   <= '0;
            r_cnt      <= '0;
            r_imem_req <= 1'b0;
            r_illegal  <= 1'b0;
            r_bus_err  <= 1'b0;
        end else begin
            case (r_state)
                S_FETCH: begin
                    if (!r_imem_req) begin
                        r_imem_req <= 1'b1;
                        r_cnt      <= '0;
                    end else if (imem_ack) begin
                        r_imem_req <= 1'b0;
                        r_opcode   <= instr[6:0];
                        r_state    <= S_DECODE;
                    end else if (w_timeout) begin
                        r_imem_req <= 1'b0;
                        r_bus_err  <= 1'b1;
                        r_state    <= S_HALT;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                S_DECODE: begin
                    if (w_legal) begin
                        r_state <= S_EXEC;
                    end else if (ILLEGAL_HALT) begin
                        r_illegal <= 1'b1;
                        r_state   <= S_HALT;
                    end else begin
                        r_state    <= S_FETCH;
                        r_imem_req <= 1'b1;
                        r_cnt      <= '0;
                    end
                end
                S_EXEC: begin
                    if (w_is_branch) begin
                        r_state    <= S_FETCH;
                        r_imem_req <= 1'b1;
                        r_cnt      <= '0;
                    end else if (w_is_load || w_is_store) begin
                        r_state <= S_MEM;
                        r_cnt   <= '0;
                    end else begin
                        r_state <= S_WB;
                    end
                end
                S_MEM: begin
                    if (dmem_ack) begin
                        if (w_is_store) begin
                            r_state    <= S_FETCH;
                            r_imem_req <= 1'b1;
                            r_cnt      <= '0;
                        end else begin
                            r_state <= S_WB;
                        end
                    end else if (w_timeout) begin
                        r_bus_err <= 1'b1;
                        r_state   <= S_HALT;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                S_WB: begin
                    r_state    <= S_FETCH;
                    r_imem_req <= 1'b1;
                    r_cnt      <= '0;
                end
                S_HALT: begin
                    r_state <= S_HALT;
                end
                default: begin
                    r_state    <= S_FETCH;
                    r_imem_req <= 1'b0;
                end
            endcase
        end
    end

    // Per-state datapath strobes; ir_we is gated by the live request so reset cannot glitch it
    always_comb begin
        ir_we         = 1'b0;
        dmem_req      = 1'b0;
        dmem_we       = 1'b0;
        alu_src_imm   = 1'b0;
        rf_we         = 1'b0;
        wb_sel_mem    = 1'b0;
        pc_we         = 1'b0;
        pc_sel_branch = 1'b0;
        retired       = 1'b0;
        case (r_state)
            S_FETCH: begin
                ir_we = r_imem_req & imem_ack;
            end
            S_DECODE: begin
                pc_we = ~w_legal & ~ILLEGAL_HALT;
            end
            S_EXEC: begin
                alu_src_imm = w_is_opimm | w_is_load | w_is_store;
                if (w_is_branch) begin
                    pc_we         = 1'b1;
                    pc_sel_branch = br_taken;
                    retired       = 1'b1;
                end
            end
            S_MEM: begin
                dmem_req = 1'b1;
                dmem_we  = w_is_store;
                if (dmem_ack && w_is_store) begin
                    pc_we   = 1'b1;
                    retired = 1'b1;
                end
            end
            S_WB: begin
                rf_we      = 1'b1;
                wb_sel_mem = w_is_load;
                pc_we      = 1'b1;
                retired    = 1'b1;
            end
            default: begin
                ir_we = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Self-checking bench for multicycle_ctrl: directed and randomized instructions
// checked against a per-instruction cycle/strobe model.
module tb_multicycle_ctrl;

    logic        clk;
    logic        rst_n, rst_n_b;
    logic        imem_ack, dmem_ack, br_taken;
    logic [31:0] instr;

    logic        imem_req, ir_we, dmem_req, dmem_we, alu_src_imm, rf_we, wb_sel_mem;
    logic        pc_we, pc_sel_branch, retired, illegal, bus_err;
    logic [2:0]  state;

    logic        imem_req_b, ir_we_b, dmem_req_b, dmem_we_b, alu_src_imm_b, rf_we_b, wb_sel_mem_b;
    logic        pc_we_b, pc_sel_branch_b, retired_b, illegal_b, bus_err_b;
    logic [2:0]  state_b;

    int total = 0;
    int bad   = 0;

    multicycle_ctrl #(.MEM_TIMEOUT(16), .ILLEGAL_HALT(1'b1)) u_dut (
        .clk(clk), .rst_n(rst_n),
        .imem_req(imem_req), .imem_ack(imem_ack), .instr(instr), .ir_we(ir_we),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_ack(dmem_ack), .br_taken(br_taken),
        .alu_src_imm(alu_src_imm), .rf_we(rf_we), .wb_sel_mem(wb_sel_mem),
        .pc_we(pc_we), .pc_sel_branch(pc_sel_branch), .retired(retired),
        .illegal(illegal), .bus_err(bus_err), .state(state)
    );

    multicycle_ctrl #(.MEM_TIMEOUT(16), .ILLEGAL_HALT(1'b0)) u_dut_skip (
        .clk(clk), .rst_n(rst_n_b),
        .imem_req(imem_req_b), .imem_ack(imem_ack), .instr(instr), .ir_we(ir_we_b),
        .dmem_req(dmem_req_b), .dmem_we(dmem_we_b), .dmem_ack(dmem_ack), .br_taken(br_taken),
        .alu_src_imm(alu_src_imm_b), .rf_we(rf_we_b), .wb_sel_mem(wb_sel_mem_b),
        .pc_we(pc_we_b), .pc_sel_branch(pc_sel_branch_b), .retired(retired_b),
        .illegal(illegal_b), .bus_err(bus_err_b), .state(state_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    localparam logic [31:0] W_ADDI = 32'h00500093;
    localparam logic [31:0] W_LW   = 32'h0000A103;
    localparam logic [31:0] W_SW   = 32'h0020A023;
    localparam logic [31:0] W_BEQ  = 32'h00208463;
    localparam logic [31:0] W_BNE  = 32'h00209463;
    localparam logic [31:0] W_ADD  = 32'h002081B3;
    localparam logic [31:0] W_ILL  = 32'h0000007F;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reset dut A with noisy acks, then release; request must rise one edge later
    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0; imem_ack = 1'b1; dmem_ack = 1'b1;
        #1;
        chk("rst_state", 32'(state), 0);
        chk("rst_imem_req", 32'(imem_req), 0);
        chk("rst_ir_we", 32'(ir_we), 0);
        chk("rst_pc_we", 32'(pc_we), 0);
        chk("rst_retired", 32'(retired), 0);
        chk("rst_dmem_req", 32'(dmem_req), 0);
        chk("rst_illegal", 32'(illegal), 0);
        chk("rst_bus_err", 32'(bus_err), 0);
        @(negedge clk);
        rst_n = 1'b1; imem_ack = 1'b0; dmem_ack = 1'b0;
        #1;
        chk("rel_req_low", 32'(imem_req), 0);
        @(posedge clk); #1;
        chk("rel_req_high", 32'(imem_req), 1);
        chk("rel_state", 32'(state), 0);
    endtask

    // Run one legal instruction on dut A and compare against cycle/strobe expectations
    task automatic run_instr(input string name, input logic [31:0] word,
                             input int di, input int dd, input logic bt);
        int cyc = 0, req_seen = 0, dm_seen = 0;
        int n_ir = 0, n_rf = 0, n_pc = 0, n_ret = 0, n_dreq = 0, n_dwe = 0, n_alu = 0;
        int ret_cyc = -1, exp_cyc;
        logic pcsel = 1'b0, wbsel = 1'b0;
        bit done = 1'b0;
        logic [6:0] op;
        bit is_ld, is_st, is_br, is_alu;
        op     = word[6:0];
        is_ld  = (op == 7'b0000011);
        is_st  = (op == 7'b0100011);
        is_br  = (op == 7'b1100011);
        is_alu = (op == 7'b0110011) || (op == 7'b0010011);
        exp_cyc = (di + 1) + 2 + ((is_ld || is_st) ? dd + 1 : 0) + ((is_ld || is_alu) ? 1 : 0);
        while (!done && cyc < 200) begin
            @(negedge clk);
            instr    = word;
            br_taken = bt;
            imem_ack = imem_req ? logic'(req_seen == di) : logic'($urandom_range(0, 1));
            dmem_ack = dmem_req ? logic'(dm_seen == dd) : logic'($urandom_range(0, 1));
            #1;
            n_ir   += int'(ir_we);
            n_rf   += int'(rf_we);
            n_pc   += int'(pc_we);
            n_ret  += int'(retired);
            n_dreq += int'(dmem_req);
            n_dwe  += int'(dmem_we);
            n_alu  += int'(alu_src_imm);
            if (rf_we) wbsel = wb_sel_mem;
            if (retired) ret_cyc = cyc;
            if (pc_we) begin
                pcsel = pc_sel_branch;
                done  = 1'b1;
            end
            if (imem_req) req_seen++;
            if (dmem_req) dm_seen++;
            cyc++;
        end
        @(posedge clk); #1;
        imem_ack = 1'b0; dmem_ack = 1'b0;
        chk({name, " cycles"}, 32'(cyc), 32'(exp_cyc));
        chk({name, " ir_we"}, 32'(n_ir), 1);
        chk({name, " pc_we"}, 32'(n_pc), 1);
        chk({name, " retired"}, 32'(n_ret), 1);
        chk({name, " ret_cyc"}, 32'(ret_cyc), 32'(exp_cyc - 1));
        chk({name, " rf_we"}, 32'(n_rf), (is_ld || is_alu) ? 1 : 0);
        chk({name, " dmem_req"}, 32'(n_dreq), (is_ld || is_st) ? 32'(dd + 1) : 0);
        chk({name, " dmem_we"}, 32'(n_dwe), is_st ? 32'(dd + 1) : 0);
        chk({name, " alu_imm"}, 32'(n_alu), (is_ld || is_st || op == 7'b0010011) ? 1 : 0);
        chk({name, " pc_sel"}, 32'(pcsel), is_br ? 32'(bt) : 0);
        chk({name, " wb_sel"}, 32'(wbsel), is_ld ? 1 : 0);
        chk({name, " next_fetch"}, {29'd0, state}, 0);
        chk({name, " next_req"}, 32'(imem_req), 1);
        chk({name, " bus_err"}, 32'(bus_err), 0);
    endtask

    initial begin
        logic [6:0]  ops [5];
        logic [31:0] w;
        ops[0] = 7'b0010011; ops[1] = 7'b0000011; ops[2] = 7'b0100011;
        ops[3] = 7'b1100011; ops[4] = 7'b0110011;
        rst_n = 1'b0; rst_n_b = 1'b0;
        imem_ack = 1'b0; dmem_ack = 1'b0; br_taken = 1'b0; instr = '0;
        repeat (2) @(posedge clk);

        do_reset();
        run_instr("addi_zw", W_ADDI, 0, 0, 1'b0);
        run_instr("lw_late3", W_LW, 0, 3, 1'b0);
        run_instr("beq_taken", W_BEQ, 0, 0, 1'b1);
        run_instr("bne_not", W_BNE, 0, 0, 1'b0);
        run_instr("add_zw", W_ADD, 0, 0, 1'b1);
        run_instr("sw_zw", W_SW, 0, 0, 1'b0);
        run_instr("addi_ack15", W_ADDI, 15, 0, 1'b0);
        run_instr("sw_ack15", W_SW, 2, 15, 1'b1);

        for (int i = 0; i < 40; i++) begin
            w = $urandom();
            w[6:0] = ops[$urandom_range(0, 4)];
            run_instr("rand", w, $urandom_range(0, 5), $urandom_range(0, 5), logic'($urandom_range(0, 1)));
        end

        // Reset asserted in the middle of a store's MEM phase
        @(negedge clk); instr = W_SW; imem_ack = 1'b1;
        @(negedge clk); imem_ack = 1'b0;
        @(negedge clk);
        @(negedge clk); dmem_ack = 1'b0;
        #1;
        chk("sw_mem_state", 32'(state), 3);
        chk("sw_mem_req", 32'(dmem_req), 1);
        chk("sw_mem_we", 32'(dmem_we), 1);
        #2; rst_n = 1'b0; dmem_ack = 1'b1;
        #1;
        chk("midrst_state", 32'(state), 0);
        chk("midrst_dmem_req", 32'(dmem_req), 0);
        chk("midrst_pc_we", 32'(pc_we), 0);
        chk("midrst_retired", 32'(retired), 0);
        @(negedge clk); rst_n = 1'b1; dmem_ack = 1'b0;
        #1;
        chk("midrst_rel_req0", 32'(imem_req), 0);
        @(posedge clk); #1;
        chk("midrst_rel_req1", 32'(imem_req), 1);

        // Instruction fetch ack withheld: error after MEM_TIMEOUT request cycles
        for (int k = 0; k < 16; k++) begin
            @(negedge clk); imem_ack = 1'b0;
            #1;
            if (k == 15) begin
                chk("ito_req_c15", 32'(imem_req), 1);
                chk("ito_noerr_c15", 32'(bus_err), 0);
            end
        end
        @(negedge clk); #1;
        chk("ito_bus_err", 32'(bus_err), 1);
        chk("ito_state", 32'(state), 5);
        chk("ito_req", 32'(imem_req), 0);
        do_reset();

        // Illegal opcode halts the core
        @(negedge clk); instr = W_ILL; imem_ack = 1'b1;
        #1; chk("ill_ir_we", 32'(ir_we), 1);
        @(negedge clk); imem_ack = 1'b0;
        #1;
        chk("ill_decode", 32'(state), 1);
        chk("ill_dec_pc_we", 32'(pc_we), 0);
        @(negedge clk); #1;
        chk("ill_halt", 32'(state), 5);
        chk("ill_flag", 32'(illegal), 1);
        chk("ill_req", 32'(imem_req), 0);
        repeat (3) begin
            @(negedge clk); imem_ack = logic'($urandom_range(0, 1)); dmem_ack = 1'b1;
        end
        #1;
        chk("ill_hold_state", 32'(state), 5);
        chk("ill_hold_req", 32'(imem_req), 0);
        chk("ill_hold_ir_we", 32'(ir_we), 0);
        chk("ill_hold_retired", 32'(retired), 0);
        do_reset();

        // Data ack withheld on a store
        @(negedge clk); instr = W_SW; imem_ack = 1'b1;
        @(negedge clk); imem_ack = 1'b0;
        @(negedge clk);
        begin
            int nreq = 0;
            for (int k = 0; k < 16; k++) begin
                @(negedge clk); dmem_ack = 1'b0;
                #1; nreq += int'(dmem_req);
            end
            chk("dto_req_cycles", 32'(nreq), 16);
        end
        @(negedge clk); #1;
        chk("dto_bus_err", 32'(bus_err), 1);
        chk("dto_state", 32'(state), 5);
        chk("dto_dmem_req", 32'(dmem_req), 0);

        // ILLEGAL_HALT=0 instance: illegal opcode is skipped with PC+4
        @(negedge clk); rst_n = 1'b0; rst_n_b = 1'b1; imem_ack = 1'b0;
        @(posedge clk); #1;
        chk("skip_req", 32'(imem_req_b), 1);
        @(negedge clk); instr = W_ILL; imem_ack = 1'b1;
        #1; chk("skip_ir_we", 32'(ir_we_b), 1);
        @(negedge clk); imem_ack = 1'b0;
        #1;
        chk("skip_dec_state", 32'(state_b), 1);
        chk("skip_pc_we", 32'(pc_we_b), 1);
        chk("skip_pc_sel", 32'(pc_sel_branch_b), 0);
        chk("skip_retired", 32'(retired_b), 0);
        @(posedge clk); #1;
        chk("skip_next_state", 32'(state_b), 0);
        chk("skip_next_req", 32'(imem_req_b), 1);
        chk("skip_illegal", 32'(illegal_b), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
